ex_operand_stage: RTL and testbench

- ID/EX pipeline stage directly upstream of the integer ALU.
- Registers decoded operands and control from decode and resolves operand forwarding from EX/MEM and MEM/WB.
- Detects load-use hazards and inserts a bubble; handles pipeline stall and flush.
- Drives the ALU operand and function inputs, and passes control and store data on to the EX/MEM register.

---
 rtl/core_pkg.sv | 18 +
 rtl/fwd_mux.sv | 32 +++
 rtl/ex_operand_stage.sv | 150 +++++++++++++++
 tb/tb_ex_operand_stage.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core constants: datapath widths and ALU function encodings.
// Imported by the pipeline stages and their helpers.
package core_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int FUNC_W = 4;

  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b0001,
    ALU_MUL = 4'b0010,
    ALU_DIV = 4'b0011,
    ALU_AND = 4'b0100,
    ALU_OR  = 4'b0101
  } alu_func_e;

endpackage

// File: rtl/fwd_mux.sv
// Priority operand forwarding for one source register.
// EX/MEM beats MEM/WB; loads in EX/MEM cannot forward yet.
module fwd_mux
  import core_pkg::*;
#(
  parameter int DATA_W = core_pkg::DATA_W,
  parameter int REG_AW = core_pkg::REG_AW
) (
  input  logic [REG_AW-1:0] idx,
  input  logic [DATA_W-1:0] rf_val,
  input  logic              exm_reg_write,
  input  logic              exm_mem_read,
  input  logic [REG_AW-1:0] exm_rd,
  input  logic [DATA_W-1:0] exm_value,
  input  logic              mwb_reg_write,
  input  logic [REG_AW-1:0] mwb_rd,
  input  logic [DATA_W-1:0] mwb_value,
  output logic [DATA_W-1:0] val
);

  always_comb begin
    val = rf_val;
    if (idx == '0) begin
      val = '0;
    end else if (exm_reg_write && !exm_mem_read && exm_rd == idx) begin
      val = exm_value;
    end else if (mwb_reg_write && mwb_rd == idx) begin
      val = mwb_value;
    end
  end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX register with forwarding, load-use bubbles, stall and flush.
// Drives ALU operands and passes control on to EX/MEM.
module ex_operand_stage
  import core_pkg::*;
#(
  parameter int DATA_W = core_pkg::DATA_W,
  parameter int REG_AW = core_pkg::REG_AW,
  parameter int FUNC_W = core_pkg::FUNC_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [DATA_W-1:0] id_rs_val,
  input  logic [DATA_W-1:0] id_rt_val,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              id_use_imm,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [FUNC_W-1:0] id_func,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              exm_reg_write,
  input  logic              exm_mem_read,
  input  logic [REG_AW-1:0] exm_rd,
  input  logic [DATA_W-1:0] exm_value,
  input  logic              mwb_reg_write,
  input  logic [REG_AW-1:0] mwb_rd,
  input  logic [DATA_W-1:0] mwb_value,
  input  logic              mem_stall,
  input  logic              flush,
  output logic [DATA_W-1:0] alu_inA,
  output logic [DATA_W-1:0] alu_inB,
  output logic [FUNC_W-1:0] alu_func,
  output logic              ex_valid,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic [REG_AW-1:0] ex_rd,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [CNT_W-1:0]  bubble_count
);

  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              use_imm;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [FUNC_W-1:0] func;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
    logic [DATA_W-1:0] imm;
  } ex_t;

  ex_t              ex_q, ex_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hz;
  logic [DATA_W-1:0] fwd_a, fwd_b;

  // Load in EX feeding a source that decode actually reads.
  always_comb begin
    hz = id_valid & ex_q.valid & ex_q.mem_read
       & (ex_q.rd != '0)
       & ((ex_q.rd == id_rs)
         | ((ex_q.rd == id_rt)
           & (!id_use_imm | id_mem_write)));
    id_ready = !mem_stall & !hz;
  end

  always_comb begin
    ex_d  = '0;
    cnt_d = cnt_q;
    if (flush) begin
      ex_d = '0;
    end else if (mem_stall) begin
      ex_d = ex_q;
    end else if (hz) begin
      ex_d = '0;
      if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end else if (id_valid) begin
      ex_d.valid     = 1'b1;
      ex_d.reg_write = id_reg_write;
      ex_d.mem_read  = id_mem_read;
      ex_d.mem_write = id_mem_write;
      ex_d.use_imm   = id_use_imm;
      ex_d.rd        = id_rd;
      ex_d.rs        = id_rs;
      ex_d.rt        = id_rt;
      ex_d.func      = id_func;
      ex_d.rs_val    = id_rs_val;
      ex_d.rt_val    = id_rt_val;
      ex_d.imm       = id_imm;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

  fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs (
    .idx           (ex_q.rs),
    .rf_val        (ex_q.rs_val),
    .exm_reg_write (exm_reg_write),
    .exm_mem_read  (exm_mem_read),
    .exm_rd        (exm_rd),
    .exm_value     (exm_value),
    .mwb_reg_write (mwb_reg_write),
    .mwb_rd        (mwb_rd),
    .mwb_value     (mwb_value),
    .val           (fwd_a)
  );

  fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rt (
    .idx           (ex_q.rt),
    .rf_val        (ex_q.rt_val),
    .exm_reg_write (exm_reg_write),
    .exm_mem_read  (exm_mem_read),
    .exm_rd        (exm_rd),
    .exm_value     (exm_value),
    .mwb_reg_write (mwb_reg_write),
    .mwb_rd        (mwb_rd),
    .mwb_value     (mwb_value),
    .val           (fwd_b)
  );

  assign alu_inA       = fwd_a;
  assign alu_inB       = ex_q.use_imm ? ex_q.imm : fwd_b;
  assign ex_store_data = fwd_b;
  assign alu_func      = ex_q.func;
  assign ex_valid      = ex_q.valid;
  assign ex_reg_write  = ex_q.reg_write;
  assign ex_mem_read   = ex_q.mem_read;
  assign ex_mem_write  = ex_q.mem_write;
  assign ex_rd         = ex_q.rd;
  assign bubble_count  = cnt_q;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Randomized bench for ex_operand_stage against a record-level model,
// plus directed literal checks of forwarding, hazards, stall and reset.
module tb_ex_operand_stage;

  logic clk = 1'b0;
  logic rst;
  logic id_valid, id_use_imm, id_reg_write, id_mem_read, id_mem_write;
  logic [31:0] id_rs_val, id_rt_val, id_imm;
  logic [4:0] id_rs, id_rt, id_rd;
  logic [3:0] id_func;
  logic exm_reg_write, exm_mem_read, mwb_reg_write;
  logic [4:0] exm_rd, mwb_rd;
  logic [31:0] exm_value, mwb_value;
  logic mem_stall, flush;

  logic id_ready, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
  logic [31:0] alu_inA, alu_inB, ex_store_data;
  logic [3:0] alu_func;
  logic [4:0] ex_rd;
  logic [15:0] bubble_count;

  logic id_ready2, ex_valid2, ex_reg_write2, ex_mem_read2, ex_mem_write2;
  logic [31:0] alu_inA2, alu_inB2, ex_store_data2;
  logic [3:0] alu_func2;
  logic [4:0] ex_rd2;
  logic [1:0] bubble_count2;

  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ex_operand_stage dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_rs_val(id_rs_val), .id_rt_val(id_rt_val),
    .id_imm(id_imm), .id_use_imm(id_use_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_func(id_func), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .exm_reg_write(exm_reg_write), .exm_mem_read(exm_mem_read),
    .exm_rd(exm_rd), .exm_value(exm_value),
    .mwb_reg_write(mwb_reg_write), .mwb_rd(mwb_rd),
    .mwb_value(mwb_value),
    .mem_stall(mem_stall), .flush(flush),
    .alu_inA(alu_inA), .alu_inB(alu_inB), .alu_func(alu_func),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_rd(ex_rd), .ex_store_data(ex_store_data),
    .bubble_count(bubble_count)
  );

  ex_operand_stage #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_ready(id_ready2),
    .id_rs_val(id_rs_val), .id_rt_val(id_rt_val),
    .id_imm(id_imm), .id_use_imm(id_use_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_func(id_func), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .exm_reg_write(exm_reg_write), .exm_mem_read(exm_mem_read),
    .exm_rd(exm_rd), .exm_value(exm_value),
    .mwb_reg_write(mwb_reg_write), .mwb_rd(mwb_rd),
    .mwb_value(mwb_value),
    .mem_stall(mem_stall), .flush(flush),
    .alu_inA(alu_inA2), .alu_inB(alu_inB2), .alu_func(alu_func2),
    .ex_valid(ex_valid2), .ex_reg_write(ex_reg_write2),
    .ex_mem_read(ex_mem_read2), .ex_mem_write(ex_mem_write2),
    .ex_rd(ex_rd2), .ex_store_data(ex_store_data2),
    .bubble_count(bubble_count2)
  );

  typedef struct {
    bit          valid, rw, mr, mw, ui;
    int unsigned rd, rs, rt, func;
    bit [31:0]   rsv, rtv, imm;
  } instr_t;

  instr_t m;
  instr_t bubble_rec;
  int unsigned m_cnt;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit [31:0] fwd(input int unsigned idx,
                                    input bit [31:0] rfv);
    if (idx == 0) return 0;
    if (exm_reg_write && !exm_mem_read && exm_rd == idx) return exm_value;
    if (mwb_reg_write && mwb_rd == idx) return mwb_value;
    return rfv;
  endfunction

  function automatic bit load_use();
    bit uses_rt;
    uses_rt = (m.rd == id_rt) && (!id_use_imm || id_mem_write);
    return id_valid && m.valid && m.mr && m.rd != 0
           && (m.rd == id_rs || uses_rt);
  endfunction

  task automatic compare_all();
    int unsigned c16, c2;
    c16 = (m_cnt > 65535) ? 65535 : m_cnt;
    c2  = (m_cnt > 3) ? 3 : m_cnt;
    chk("id_ready", id_ready, !mem_stall && !load_use());
    chk("alu_inA", alu_inA, fwd(m.rs, m.rsv));
    chk("alu_inB", alu_inB, m.ui ? m.imm : fwd(m.rt, m.rtv));
    chk("store_data", ex_store_data, fwd(m.rt, m.rtv));
    chk("alu_func", alu_func, m.func);
    chk("ex_valid", ex_valid, m.valid);
    chk("ex_reg_write", ex_reg_write, m.rw);
    chk("ex_mem_read", ex_mem_read, m.mr);
    chk("ex_mem_write", ex_mem_write, m.mw);
    chk("ex_rd", ex_rd, m.rd);
    chk("bubble_count", bubble_count, c16);
    chk("bubble_count_sat", bubble_count2, c2);
  endtask

  // One cycle: check outputs, predict the next EX record, cross the edge.
  task automatic tick();
    instr_t nx;
    bit inc;
    #1;
    compare_all();
    inc = 0;
    if (flush) nx = bubble_rec;
    else if (mem_stall) nx = m;
    else if (load_use()) begin
      nx = bubble_rec;
      inc = 1;
    end else if (id_valid) begin
      nx.valid = 1; nx.rw = id_reg_write;
      nx.mr = id_mem_read; nx.mw = id_mem_write;
      nx.ui = id_use_imm; nx.rd = id_rd;
      nx.rs = id_rs; nx.rt = id_rt; nx.func = id_func;
      nx.rsv = id_rs_val; nx.rtv = id_rt_val; nx.imm = id_imm;
    end else nx = bubble_rec;
    @(posedge clk);
    m = nx;
    if (inc) m_cnt++;
    @(negedge clk);
  endtask

  task automatic clr_in();
    id_valid = 0; id_use_imm = 0; id_reg_write = 0;
    id_mem_read = 0; id_mem_write = 0;
    id_rs_val = 0; id_rt_val = 0; id_imm = 0;
    id_rs = 0; id_rt = 0; id_rd = 0; id_func = 0;
    exm_reg_write = 0; exm_mem_read = 0; exm_rd = 0; exm_value = 0;
    mwb_reg_write = 0; mwb_rd = 0; mwb_value = 0;
    mem_stall = 0; flush = 0;
  endtask

  task automatic rand_in();
    id_valid = ($urandom_range(0, 9) < 8);
    id_use_imm = $urandom_range(0, 1);
    id_reg_write = $urandom_range(0, 1);
    id_mem_read = ($urandom_range(0, 9) < 4);
    id_mem_write = ($urandom_range(0, 9) < 2);
    id_rs_val = $urandom; id_rt_val = $urandom; id_imm = $urandom;
    id_rs = 5'($urandom_range(0, 7));
    id_rt = 5'($urandom_range(0, 7));
    id_rd = 5'($urandom_range(0, 7));
    id_func = 4'($urandom_range(0, 5));
    exm_reg_write = $urandom_range(0, 1);
    exm_mem_read = ($urandom_range(0, 9) < 3);
    exm_rd = 5'($urandom_range(0, 7));
    exm_value = $urandom;
    mwb_reg_write = $urandom_range(0, 1);
    mwb_rd = 5'($urandom_range(0, 7));
    mwb_value = $urandom;
    mem_stall = ($urandom_range(0, 99) < 15);
    flush = ($urandom_range(0, 99) < 8);
  endtask

  task automatic do_reset();
    rst = 1;
    m = bubble_rec;
    m_cnt = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    bubble_rec = '{default: 0};
    m = bubble_rec;
    m_cnt = 0;
    clr_in();
    rst = 1;
    #2;
    chk("reset ex_valid", ex_valid, 0);
    chk("reset alu_func", alu_func, 0);
    chk("reset bubble_count", bubble_count, 0);
    chk("reset alu_inA", alu_inA, 0);
    @(negedge clk);
    rst = 0;

    // EX/MEM forward beats MEM/WB
    id_valid = 1; id_rs = 3; id_rs_val = 5;
    tick();
    clr_in();
    exm_reg_write = 1; exm_rd = 3; exm_value = 32'h10;
    #1 chk("fwd exm", alu_inA, 32'h10);
    mwb_reg_write = 1; mwb_rd = 3; mwb_value = 32'h20;
    #1 chk("fwd exm over mwb", alu_inA, 32'h10);
    tick();

    // Register zero never forwards
    clr_in();
    id_valid = 1; id_rs = 0; id_rs_val = 32'h77;
    tick();
    clr_in();
    exm_reg_write = 1; exm_rd = 0; exm_value = 32'hFFFF;
    #1 chk("r0 zero", alu_inA, 0);
    tick();

    // Load-use: one bubble, then accept with MEM/WB value
    clr_in();
    id_valid = 1; id_mem_read = 1; id_reg_write = 1;
    id_rd = 4; id_rs = 1;
    tick();
    clr_in();
    id_valid = 1; id_rs = 2; id_rt = 4; id_rt_val = 32'h1;
    #1 chk("lu id_ready low", id_ready, 0);
    tick();
    chk("lu bubble_count", bubble_count, 1);
    chk("lu bubble ex_valid", ex_valid, 0);
    mwb_reg_write = 1; mwb_rd = 4; mwb_value = 32'hABCD;
    #1 chk("lu id_ready back", id_ready, 1);
    tick();
    #1 chk("lu fwd store", ex_store_data, 32'hABCD);
    chk("lu fwd inB", alu_inB, 32'hABCD);
    tick();

    // Stall holds EX, flush during stall kills it
    clr_in();
    id_valid = 1; id_rd = 7; id_func = 4'b0001; id_reg_write = 1;
    tick();
    mem_stall = 1; id_rd = 9; id_func = 4'b0010;
    #1 chk("stall id_ready", id_ready, 0);
    tick();
    chk("stall hold rd 1", ex_rd, 7);
    tick();
    chk("stall hold rd 2", ex_rd, 7);
    chk("stall hold func", alu_func, 4'b0001);
    flush = 1;
    #1 chk("flush keeps id_ready", id_ready, 0);
    tick();
    chk("flush kills", ex_valid, 0);
    clr_in();
    tick();

    // Random traffic against the model
    for (int i = 0; i < 2000; i++) begin
      rand_in();
      tick();
    end

    // Async reset mid-operation
    clr_in();
    id_valid = 1; id_rd = 6; id_func = 4'b0101; id_rs = 2;
    id_rs_val = 32'h1234;
    tick();
    #1 chk("pre-reset valid", ex_valid, 1);
    rst = 1;
    #1;
    chk("async rst ex_valid", ex_valid, 0);
    chk("async rst alu_func", alu_func, 0);
    chk("async rst bubble_count", bubble_count, 0);
    chk("async rst alu_inA", alu_inA, 0);
    clr_in();
    do_reset();

    // Saturation of the 2-bit counter
    for (int k = 0; k < 5; k++) begin
      clr_in();
      id_valid = 1; id_mem_read = 1; id_reg_write = 1;
      id_rd = 4; id_rs = 1; id_rt = 2;
      tick();
      id_mem_read = 0; id_rs = 4;
      tick();
    end
    chk("sat count 2-bit", bubble_count2, 3);
    chk("count 16-bit", bubble_count, 5);
    clr_in();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
